// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: instruction-memory request/return and the decode-side valid/ready queue head.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;

  modport master (
    output imem_req, imem_addr, out_valid, out_pc, out_instr,
    input  imem_instr, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_pc, out_instr,
    output imem_instr, out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, single outstanding imem request, and a circular fetch queue
// feeding decode; any non-zero pcsel redirects and flushes all younger work.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              PC_STEP  = 1,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              FQ_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      pcsel,
  input  logic [XLEN-1:0] b_target,
  input  logic [XLEN-1:0] trap_vec,
  fetch_unit_if.master    bus
);
  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = CW + 1;

  typedef logic [XLEN-1:0] word_t;

  word_t           pc_q, pc_d;
  word_t           req_pc_q, req_pc_d;
  logic            inflight_q, inflight_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  word_t           slot_pc_q [FQ_DEPTH];
  word_t           slot_pc_d [FQ_DEPTH];
  word_t           slot_instr_q [FQ_DEPTH];
  word_t           slot_instr_d [FQ_DEPTH];

  logic            out_valid;
  logic            deq;
  logic            enq;
  logic            issue;
  logic [OW-1:0]   occupancy;
  word_t           target;

  always_comb begin
    out_valid = (count_q != '0) && (pcsel == 2'd0);
    deq       = out_valid && bus.out_ready;
    // count + inflight - deq is the slot budget after this cycle's pending return lands
    occupancy = OW'(count_q) + OW'(inflight_q) - OW'(deq);
    issue     = !rst && (pcsel == 2'd0) && (occupancy < OW'(FQ_DEPTH));
    enq       = inflight_q && (pcsel == 2'd0);

    case (pcsel)
      2'd1:    target = RESET_PC;
      2'd2:    target = b_target;
      2'd3:    target = trap_vec;
      default: target = pc_q;
    endcase

    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    inflight_d   = inflight_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    slot_pc_d    = slot_pc_q;
    slot_instr_d = slot_instr_q;

    if (pcsel != 2'd0) begin
      pc_d       = target;
      count_d    = '0;
      head_d     = tail_q;
      inflight_d = 1'b0;
    end else begin
      inflight_d = issue;
      if (issue) begin
        req_pc_d = pc_q;
        pc_d     = pc_q + word_t'(PC_STEP);
      end
      if (enq) begin
        slot_pc_d[tail_q]    = req_pc_q;
        slot_instr_d[tail_q] = bus.imem_instr;
        tail_d               = tail_q + PW'(1);
      end
      if (deq) begin
        head_d = head_q + PW'(1);
      end
      count_d = count_q + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        slot_pc_q[i]    <= '0;
        slot_instr_q[i] <= '0;
      end
    end else begin
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      inflight_q   <= inflight_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      slot_pc_q    <= slot_pc_d;
      slot_instr_q <= slot_instr_d;
    end
  end

  assign bus.imem_req  = issue;
  assign bus.imem_addr = pc_q;
  assign bus.out_valid = out_valid;
  assign bus.out_pc    = slot_pc_q[head_q];
  assign bus.out_instr = slot_instr_q[head_q];
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle-by-cycle vector table plus back-pressure,
// mid-stream reset and PC-wrap sequences. Memory word at address a is 0x1000 + a.
module tb_fetch_unit;
  logic        clk;
  logic        rst, rst2;
  logic [1:0]  pcsel, pcsel2;
  logic [31:0] b_target, trap_vec, b_target2, trap_vec2;

  int total = 0;
  int bad   = 0;

  fetch_unit_if #(.XLEN(32)) bus  ();
  fetch_unit_if #(.XLEN(32)) bus2 ();

  fetch_unit #(.XLEN(32), .PC_STEP(1), .RESET_PC(32'h0), .FQ_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .pcsel(pcsel), .b_target(b_target), .trap_vec(trap_vec),
    .bus(bus.master)
  );

  fetch_unit #(.XLEN(32), .PC_STEP(4), .RESET_PC(32'h0), .FQ_DEPTH(4)) dut4 (
    .clk(clk), .rst(rst2), .pcsel(pcsel2), .b_target(b_target2), .trap_vec(trap_vec2),
    .bus(bus2.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.imem_req)  bus.imem_instr  <= 32'h1000 + bus.imem_addr;
    if (bus2.imem_req) bus2.imem_instr <= 32'h1000 + bus2.imem_addr;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  pcsel;
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vecs [20];

  initial begin
    int nreq;
    int found;
    int j;
    logic [31:0] wrap_pc [3];

    //           rst   sel   rdy   req   addr       vld   pc         instr
    vecs[0]  = '{1'b1, 2'd0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 32'h0000};
    vecs[1]  = '{1'b0, 2'd0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 32'h0000};
    vecs[2]  = '{1'b0, 2'd0, 1'b1, 1'b1, 32'h01, 1'b0, 32'h00, 32'h0000};
    vecs[3]  = '{1'b0, 2'd0, 1'b1, 1'b1, 32'h02, 1'b1, 32'h00, 32'h1000};
    vecs[4]  = '{1'b0, 2'd0, 1'b1, 1'b1, 32'h03, 1'b1, 32'h01, 32'h1001};
    vecs[5]  = '{1'b0, 2'd0, 1'b1, 1'b1, 32'h04, 1'b1, 32'h02, 32'h1002};
    vecs[6]  = '{1'b0, 2'd2, 1'b1, 1'b0, 32'h05, 1'b0, 32'h03, 32'h1003};
    vecs[7]  = '{1'b0, 2'd0, 1'b1, 1'b1, 32'h40, 1'b0, 32'h00, 32'h1000};
    vecs[8]  = '{1'b0, 2'd0, 1'b1, 1'b1, 32'h41, 1'b0, 32'h00, 32'h1000};
    vecs[9]  = '{1'b0, 2'd0, 1'b1, 1'b1, 32'h42, 1'b1, 32'h40, 32'h1040};
    vecs[10] = '{1'b0, 2'd0, 1'b0, 1'b1, 32'h43, 1'b1, 32'h41, 32'h1041};
    vecs[11] = '{1'b0, 2'd0, 1'b0, 1'b1, 32'h44, 1'b1, 32'h41, 32'h1041};
    vecs[12] = '{1'b0, 2'd3, 1'b1, 1'b0, 32'h45, 1'b0, 32'h41, 32'h1041};
    vecs[13] = '{1'b0, 2'd0, 1'b1, 1'b1, 32'h80, 1'b0, 32'h40, 32'h1040};
    vecs[14] = '{1'b0, 2'd0, 1'b1, 1'b1, 32'h81, 1'b0, 32'h40, 32'h1040};
    vecs[15] = '{1'b0, 2'd0, 1'b1, 1'b1, 32'h82, 1'b1, 32'h80, 32'h1080};
    vecs[16] = '{1'b0, 2'd1, 1'b1, 1'b0, 32'h83, 1'b0, 32'h81, 32'h1081};
    vecs[17] = '{1'b0, 2'd0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h42, 32'h1042};
    vecs[18] = '{1'b0, 2'd0, 1'b1, 1'b1, 32'h01, 1'b0, 32'h42, 32'h1042};
    vecs[19] = '{1'b0, 2'd0, 1'b1, 1'b1, 32'h02, 1'b1, 32'h00, 32'h1000};

    rst = 1'b1; pcsel = 2'd0; b_target = 32'h40; trap_vec = 32'h80; bus.out_ready = 1'b0;
    rst2 = 1'b1; pcsel2 = 2'd0; b_target2 = 32'h0; trap_vec2 = 32'h0; bus2.out_ready = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 20; v++) begin
      rst = vecs[v].rst; pcsel = vecs[v].pcsel; bus.out_ready = vecs[v].ready;
      #1;
      chk($sformatf("v%0d_req", v),   32'(bus.imem_req),  32'(vecs[v].e_req));
      chk($sformatf("v%0d_addr", v),  bus.imem_addr,      vecs[v].e_addr);
      chk($sformatf("v%0d_valid", v), 32'(bus.out_valid), 32'(vecs[v].e_valid));
      chk($sformatf("v%0d_pc", v),    bus.out_pc,         vecs[v].e_pc);
      chk($sformatf("v%0d_instr", v), bus.out_instr,      vecs[v].e_instr);
      @(negedge clk);
    end
    pcsel = 2'd0;

    // back-pressure from reset: exactly four requests, then resume without loss
    rst = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    nreq = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (bus.imem_req) begin
        chk("bp_addr", bus.imem_addr, 32'(nreq));
        nreq++;
      end
      @(negedge clk);
    end
    #1;
    chk("bp_nreq", 32'(nreq), 32'd4);
    chk("bp_req_idle", 32'(bus.imem_req), 32'd0);
    chk("bp_valid", 32'(bus.out_valid), 32'd1);
    @(negedge clk);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (i == 0) chk("resume_req", 32'(bus.imem_req), 32'd1);
      chk("resume_valid", 32'(bus.out_valid), 32'd1);
      chk("resume_pc", bus.out_pc, 32'(i));
      chk("resume_instr", bus.out_instr, 32'h1000 + 32'(i));
      @(negedge clk);
    end

    // one-cycle reset with a full queue
    bus.out_ready = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_out_pc", bus.out_pc, 32'h0);
    chk("rst_out_instr", bus.out_instr, 32'h0);
    bus.out_ready = 1'b1;
    found = -1;
    for (int k = 0; k < 6 && found < 0; k++) begin
      if (k > 0) #1;
      if (bus.out_valid) begin
        found = k;
        chk("rst_first_pc", bus.out_pc, 32'h0);
        chk("rst_first_instr", bus.out_instr, 32'h1000);
      end
      @(negedge clk);
    end
    chk("rst_first_latency", 32'(found), 32'd2);

    // PC_STEP=4 instance: branch near the top of the address space and wrap
    wrap_pc[0] = 32'hFFFF_FFF8; wrap_pc[1] = 32'hFFFF_FFFC; wrap_pc[2] = 32'h0;
    rst2 = 1'b0; pcsel2 = 2'd2; b_target2 = 32'hFFFF_FFF8; bus2.out_ready = 1'b1;
    @(negedge clk);
    pcsel2 = 2'd0;
    j = 0;
    for (int k = 0; k < 10 && j < 3; k++) begin
      #1;
      if (bus2.out_valid) begin
        chk("wrap_pc", bus2.out_pc, wrap_pc[j]);
        chk("wrap_instr", bus2.out_instr, wrap_pc[j] + 32'h1000);
        j++;
      end
      @(negedge clk);
    end
    chk("wrap_count", 32'(j), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
